// File: rtl/tlc549_emu_pkg.sv
// Shared definitions for the TLC549 serial ADC emulator: frame states,
// result width and the default conversion time.
package tlc549_emu_pkg;

    localparam int TLC549_BITS         = 8;
    localparam int CONV_CYCLES_DEFAULT = 1700;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        HOLD
    } state_t;

endpackage

// File: rtl/tlc549_emulator_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin, with rise/fall detection
// on the synchronized level. RESET_VAL sets the idle level of every stage.
module sync_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_in,
    input  logic reset,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
            r_prev <= RESET_VAL;
        end else begin
            r_meta <= async_in;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign level = r_sync;
    assign rise  = r_sync & ~r_prev;
    assign fall  = ~r_sync & r_prev;

endmodule

// File: rtl/tlc549_emulator.sv
// TLC549 serial ADC responder: shifts the last conversion result out on CS/ADC_clk
// and captures a new sample per full frame. TLC549_EMU_STATS_EN adds frame/error counters.
module tlc549_emulator
    import tlc549_emu_pkg::*;
#(
    parameter int CONV_CYCLES = CONV_CYCLES_DEFAULT
) (
    input  logic                   clk_in,
    input  logic                   reset,
    input  logic                   CS,
    input  logic                   ADC_clk,
    input  logic [TLC549_BITS-1:0] sample_in,
    output logic                   data_out,
    output logic                   data_oe,
    output logic                   sample_req,
    output logic                   busy,
    output logic                   frame_err
`ifdef TLC549_EMU_STATS_EN
    ,
    output logic [15:0]            frame_count,
    output logic [7:0]             err_count
`endif
);

    localparam int CNT_W = $clog2(CONV_CYCLES + 1);
    localparam int MSB   = TLC549_BITS - 1;

    logic w_csLevel, w_csRise, w_csFall;
    logic w_adcLevel, w_adcRise, w_adcFall;
    logic w_unusedAdc;

    state_t r_state, w_stateNext;
    logic   w_start, w_shiftEn, w_capture, w_abort;
    logic   w_resultUpdate;
    logic [TLC549_BITS-1:0] w_resultNext;

    logic [TLC549_BITS-1:0] r_shift, r_result, r_conv;
    logic [3:0]             r_bitCnt;
    logic [CNT_W-1:0]       r_convCnt;
    logic                   r_dataOut, r_dataOe, r_sampleReq, r_frameErr;
    logic [1:0]             r_settle;
    logic                   r_armed;

    sync_edge #(.RESET_VAL(1'b1)) u_csSync (
        .clk_in   (clk_in),
        .reset    (reset),
        .async_in (CS),
        .level    (w_csLevel),
        .rise     (w_csRise),
        .fall     (w_csFall)
    );

    sync_edge #(.RESET_VAL(1'b0)) u_adcSync (
        .clk_in   (clk_in),
        .reset    (reset),
        .async_in (ADC_clk),
        .level    (w_adcLevel),
        .rise     (w_adcRise),
        .fall     (w_adcFall)
    );

    assign w_unusedAdc = w_adcLevel ^ w_adcRise;

    assign w_resultUpdate = (r_convCnt == CNT_W'(1)) && !r_sampleReq;
    assign w_resultNext   = w_resultUpdate ? r_conv : r_result;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_stateNext;
    end

    // The 8th fall outranks a simultaneous CS rise so a complete frame is never lost.
    always_comb begin
        w_stateNext = r_state;
        w_start     = 1'b0;
        w_shiftEn   = 1'b0;
        w_capture   = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_csFall && r_armed) begin
                    w_start     = 1'b1;
                    w_stateNext = SHIFT;
                end
            end
            SHIFT: begin
                if (w_adcFall && r_bitCnt == 4'(MSB)) begin
                    w_capture   = 1'b1;
                    w_stateNext = w_csRise ? IDLE : HOLD;
                end else if (w_csRise) begin
                    w_abort     = 1'b1;
                    w_stateNext = IDLE;
                end else if (w_adcFall) begin
                    w_shiftEn   = 1'b1;
                end
            end
            HOLD: begin
                if (w_csRise) w_stateNext = IDLE;
            end
            default: w_stateNext = IDLE;
        endcase
    end

    // A CS that is already low when the synchronizers flush after reset is not a frame start.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_settle <= 2'd0;
            r_armed  <= 1'b0;
        end else begin
            if (r_settle != 2'd2) r_settle <= r_settle + 2'd1;
            if (r_settle == 2'd2 && w_csLevel) r_armed <= 1'b1;
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_shift     <= '0;
            r_bitCnt    <= 4'd0;
            r_dataOut   <= 1'b0;
            r_dataOe    <= 1'b0;
            r_sampleReq <= 1'b0;
            r_frameErr  <= 1'b0;
            r_conv      <= '0;
        end else begin
            r_sampleReq <= w_capture;
            r_frameErr  <= w_abort;
            r_dataOe    <= (w_stateNext != IDLE);
            if (w_start) begin
                r_shift   <= w_resultNext;
                r_dataOut <= w_resultNext[MSB];
                r_bitCnt  <= 4'd0;
            end else if (w_shiftEn || w_capture) begin
                r_shift   <= {r_shift[MSB-1:0], 1'b0};
                r_dataOut <= w_capture ? 1'b0 : r_shift[MSB-1];
                r_bitCnt  <= r_bitCnt + 4'd1;
            end else if (w_abort) begin
                r_dataOut <= 1'b0;
            end
            if (w_capture) r_conv <= sample_in;
        end
    end

    // The counter loads from the registered capture pulse, so busy trails sample_req by one cycle.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_convCnt <= '0;
            r_result  <= '0;
        end else begin
            if (r_sampleReq)            r_convCnt <= CNT_W'(CONV_CYCLES);
            else if (r_convCnt != '0)   r_convCnt <= r_convCnt - CNT_W'(1);
            if (w_resultUpdate)         r_result  <= r_conv;
        end
    end

    assign data_out   = r_dataOut;
    assign data_oe    = r_dataOe;
    assign sample_req = r_sampleReq;
    assign frame_err  = r_frameErr;
    assign busy       = (r_convCnt != '0);

`ifdef TLC549_EMU_STATS_EN
    logic [15:0] r_frameCount;
    logic [7:0]  r_errCount;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_frameCount <= 16'd0;
            r_errCount   <= 8'd0;
        end else begin
            if (w_capture) r_frameCount <= r_frameCount + 16'd1;
            if (w_abort && r_errCount != 8'hFF) r_errCount <= r_errCount + 8'd1;
        end
    end

    assign frame_count = r_frameCount;
    assign err_count   = r_errCount;
`endif

endmodule

// File: tb/tb_tlc549_emulator.sv
// Testbench for tlc549_emulator: drives randomized CS/ADC_clk frames and compares
// shifted data, pulses and conversion timing against a frame-level model.
module tb_tlc549_emulator;

    localparam int CONV = 150;

    logic       clk_in = 1'b0;
    logic       reset = 1'b1;
    logic       CS = 1'b1;
    logic       ADC_clk = 1'b0;
    logic [7:0] sample_in = 8'h00;
    logic       data_out, data_oe, sample_req, busy, frame_err;
`ifdef TLC549_EMU_STATS_EN
    logic [15:0] frame_count;
    logic [7:0]  err_count;
`endif

    tlc549_emulator #(.CONV_CYCLES(CONV)) dut (
        .clk_in     (clk_in),
        .reset      (reset),
        .CS         (CS),
        .ADC_clk    (ADC_clk),
        .sample_in  (sample_in),
        .data_out   (data_out),
        .data_oe    (data_oe),
        .sample_req (sample_req),
        .busy       (busy),
        .frame_err  (frame_err)
`ifdef TLC549_EMU_STATS_EN
        ,
        .frame_count(frame_count),
        .err_count  (err_count)
`endif
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    // Frame-level reference: the readable result, the sample awaiting conversion, frame tallies.
    logic [7:0] modelResult = 8'h00;
    logic [7:0] modelPending = 8'h00;
    int         modelGood = 0;
    int         modelShort = 0;

    int   cycle = 0;
    int   reqCount = 0;
    int   errCount = 0;
    int   reqCycle = -1;
    int   busyRiseCycle = -1;
    int   busyFallCycle = -1;
    logic busyPrev = 1'b0;

    always @(posedge clk_in) cycle <= cycle + 1;

    // Event log of DUT pulses and busy edges, sampled away from the active edge.
    always @(negedge clk_in) begin
        if (sample_req) begin
            reqCount++;
            reqCycle = cycle;
        end
        if (frame_err) errCount++;
        if (busy && !busyPrev) busyRiseCycle = cycle;
        if (!busy && busyPrev) busyFallCycle = cycle;
        busyPrev = busy;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic doReset();
        reset = 1'b1;
        waitCycles(3);
        reset = 1'b0;
        waitCycles(5);
        modelResult  = 8'h00;
        modelPending = 8'h00;
        modelGood    = 0;
        modelShort   = 0;
    endtask

    // One master transaction: CS low, nFalls ADC_clk pulses, CS high; bits read before each rise.
    task automatic applyStimulus(input logic [7:0] smp, input int nFalls, input int phase,
                                 output logic [7:0] got, output logic oe);
        sample_in = smp;
        got = 8'h00;
        CS = 1'b0;
        waitCycles(phase);
        oe = data_oe;
        for (int i = 0; i < nFalls; i++) begin
            got = {got[6:0], data_out};
            ADC_clk = 1'b1;
            waitCycles(phase);
            ADC_clk = 1'b0;
            waitCycles(phase);
        end
        CS = 1'b1;
        waitCycles(phase);
    endtask

    task automatic frameAndCheck(input string tag, input logic [7:0] smp, input int nFalls,
                                 input int phase);
        logic [7:0] got;
        logic [7:0] exp;
        logic       oe;
        int         r0;
        int         e0;
        r0 = reqCount;
        e0 = errCount;
        exp = modelResult >> (8 - nFalls);
        applyStimulus(smp, nFalls, phase, got, oe);
        checkOutput({tag, "_data"}, {24'd0, got}, {24'd0, exp});
        checkOutput({tag, "_oe"}, {31'd0, oe}, 32'd1);
        if (nFalls == 8) begin
            checkOutput({tag, "_req"}, reqCount - r0, 32'd1);
            checkOutput({tag, "_err"}, errCount - e0, 32'd0);
            modelPending = smp;
            modelGood++;
        end else begin
            checkOutput({tag, "_req"}, reqCount - r0, 32'd0);
            checkOutput({tag, "_err"}, errCount - e0, 32'd1);
            modelShort++;
        end
    endtask

    // Let the conversion finish, then check busy spanned exactly CONV cycles after the last capture.
    task automatic settleAndCheck(input string tag, input bit checkRise);
        waitCycles(CONV + 20);
        if (checkRise) checkOutput({tag, "_busyRise"}, busyRiseCycle - reqCycle, 32'd1);
        checkOutput({tag, "_busyLen"}, busyFallCycle - reqCycle, CONV + 1);
        checkOutput({tag, "_busyIdle"}, {31'd0, busy}, 32'd0);
        modelResult = modelPending;
    endtask

    initial begin
        int r0;
        int nFalls;
        int phase;

        doReset();
        checkOutput("rst_data_out", {31'd0, data_out}, 32'd0);
        checkOutput("rst_data_oe", {31'd0, data_oe}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_sample_req", {31'd0, sample_req}, 32'd0);
        checkOutput("rst_frame_err", {31'd0, frame_err}, 32'd0);

        frameAndCheck("first", 8'hA5, 8, 42);
        settleAndCheck("first", 1'b1);
        frameAndCheck("second", 8'h5A, 8, 42);
        settleAndCheck("second", 1'b1);

        frameAndCheck("short5", 8'h77, 5, 10);
        frameAndCheck("afterShort", 8'h99, 8, 10);
        settleAndCheck("afterShort", 1'b1);

        frameAndCheck("overlapA", 8'h3C, 8, 5);
        checkOutput("overlap_busy", {31'd0, busy}, 32'd1);
        frameAndCheck("overlapB", 8'hC3, 8, 5);
        settleAndCheck("overlapB", 1'b0);
        frameAndCheck("readC3", 8'h11, 8, 6);
        settleAndCheck("readC3", 1'b1);

        CS = 1'b0;
        waitCycles(8);
        for (int i = 0; i < 3; i++) begin
            ADC_clk = 1'b1;
            waitCycles(6);
            ADC_clk = 1'b0;
            waitCycles(6);
        end
        doReset();
        r0 = reqCount;
        checkOutput("rstLow_oe0", {31'd0, data_oe}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            ADC_clk = 1'b1;
            waitCycles(6);
            ADC_clk = 1'b0;
            waitCycles(6);
        end
        checkOutput("rstLow_oe1", {31'd0, data_oe}, 32'd0);
        checkOutput("rstLow_req", reqCount - r0, 32'd0);
        checkOutput("rstLow_dout", {31'd0, data_out}, 32'd0);
        CS = 1'b1;
        waitCycles(10);

        frameAndCheck("stat1", 8'h12, 8, 7);
        settleAndCheck("stat1", 1'b1);
        frameAndCheck("stat2", 8'h34, 3, 7);
        frameAndCheck("stat3", 8'h56, 8, 7);
        settleAndCheck("stat3", 1'b1);
        frameAndCheck("stat4", 8'h78, 7, 7);
        frameAndCheck("stat5", 8'h9A, 8, 7);
        settleAndCheck("stat5", 1'b1);
`ifdef TLC549_EMU_STATS_EN
        checkOutput("frame_count", {16'd0, frame_count}, 32'd3);
        checkOutput("err_count", {24'd0, err_count}, 32'd2);
`endif

        for (int i = 0; i < 12; i++) begin
            phase = $urandom_range(5, 12);
            nFalls = ($urandom_range(0, 3) != 0) ? 8 : $urandom_range(1, 7);
            frameAndCheck($sformatf("rand%0d", i), 8'($urandom), nFalls, phase);
            if (nFalls == 8) settleAndCheck($sformatf("rand%0d", i), 1'b1);
        end
`ifdef TLC549_EMU_STATS_EN
        checkOutput("frame_count_end", {16'd0, frame_count}, modelGood);
        checkOutput("err_count_end", {24'd0, err_count}, modelShort);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
